// File: rtl/run_checker.sv
// Run/scan checker: lets a core run until an idle-instruction streak or the
// watchdog ends it, then scans result memory against a reference table and
// scores matching words per category.

module run_checker_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturating at all-ones so a long scan never wraps a score back to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)                    cnt_d = '0;
    else if (inc && ~&cnt_q)    cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
endmodule

module run_checker #(
  parameter int                          DATA_W    = 32,
  parameter int                          NOP_LIMIT = 9,
  parameter int                          WATCHDOG  = 500,
  parameter int                          NUM_WORDS = 22,
  parameter int                          ADDR_W    = 8,
  parameter int                          NUM_CAT   = 6,
  parameter int                          CAT_W     = 3,
  parameter logic [NUM_WORDS*CAT_W-1:0]  CAT_MAP   = '1,
  parameter int                          CNT_W     = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [DATA_W-1:0]        inst,
  output logic [ADDR_W-1:0]        mem_addr,
  input  logic [DATA_W-1:0]        mem_rdata,
  output logic [ADDR_W-1:0]        ref_addr,
  input  logic [DATA_W-1:0]        ref_rdata,
  output logic                     busy,
  output logic                     done,
  output logic                     wd_expired,
  output logic [NUM_CAT*CNT_W-1:0] cat_pass,
  output logic [CNT_W-1:0]         total_pass
);
  localparam int NOP_W = $clog2(NOP_LIMIT + 1);
  localparam int WD_W  = $clog2(WATCHDOG + 1);
  localparam int IDX_W = $clog2(NUM_WORDS + 1);

  typedef enum logic [1:0] {IDLE, RUN, SCAN, DONE} state_e;

  state_e             state_q, state_d;
  logic [NOP_W-1:0]   nop_q, nop_d;
  logic [WD_W-1:0]    wd_q, wd_d;
  logic [IDX_W-1:0]   idx_q, idx_d, cmp_idx_q, cmp_idx_d;
  logic               cmp_vld_q, cmp_vld_d;
  logic               wd_exp_q, wd_exp_d;
  logic               busy_q, busy_d, done_q, done_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d, ref_addr_q, ref_addr_d;
  logic               clr;

  always_comb begin
    state_d   = state_q;
    nop_d     = nop_q;
    wd_d      = wd_q;
    idx_d     = idx_q;
    wd_exp_d  = wd_exp_q;
    clr       = 1'b0;
    case (state_q)
      IDLE, DONE: if (start) begin
        state_d  = RUN;
        nop_d    = '0;
        wd_d     = '0;
        idx_d    = '0;
        wd_exp_d = 1'b0;
        clr      = 1'b1;
      end
      RUN: begin
        wd_d  = wd_q + WD_W'(1);
        nop_d = (inst == '0) ? nop_q + NOP_W'(1) : '0;
        // Watchdog wins the flag even when both limits land on the same edge.
        if (nop_d == NOP_W'(NOP_LIMIT) || wd_d == WD_W'(WATCHDOG)) begin
          state_d  = SCAN;
          idx_d    = '0;
          wd_exp_d = (wd_d == WD_W'(WATCHDOG));
        end
      end
      SCAN: begin
        if (idx_q == IDX_W'(NUM_WORDS)) state_d = DONE;
        else                            idx_d   = idx_q + IDX_W'(1);
      end
      default: state_d = IDLE;
    endcase

    // Read data returns one cycle after issue, so the compare trails by one.
    cmp_vld_d  = (state_q == SCAN) && (idx_q < IDX_W'(NUM_WORDS));
    cmp_idx_d  = idx_q;
    busy_d     = (state_d == RUN) || (state_d == SCAN);
    done_d     = (state_d == DONE);
    mem_addr_d = '0;
    ref_addr_d = '0;
    if (state_d == SCAN && idx_d < IDX_W'(NUM_WORDS)) begin
      mem_addr_d = ADDR_W'(idx_d) << 2;
      ref_addr_d = ADDR_W'(idx_d);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      nop_q      <= '0;
      wd_q       <= '0;
      idx_q      <= '0;
      cmp_idx_q  <= '0;
      cmp_vld_q  <= 1'b0;
      wd_exp_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      mem_addr_q <= '0;
      ref_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      nop_q      <= nop_d;
      wd_q       <= wd_d;
      idx_q      <= idx_d;
      cmp_idx_q  <= cmp_idx_d;
      cmp_vld_q  <= cmp_vld_d;
      wd_exp_q   <= wd_exp_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      mem_addr_q <= mem_addr_d;
      ref_addr_q <= ref_addr_d;
    end
  end

  logic               hit, scored;
  logic [CAT_W-1:0]   code;
  logic [NUM_CAT-1:0][CNT_W-1:0] cat_q;

  assign hit    = cmp_vld_q && (mem_rdata == ref_rdata);
  assign code   = cmp_vld_q ? CAT_MAP[int'(cmp_idx_q)*CAT_W +: CAT_W] : '1;
  assign scored = int'(code) < NUM_CAT;

  for (genvar c = 0; c < NUM_CAT; c++) begin : g_cat
    run_checker_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .inc   (hit && scored && code == CAT_W'(c)),
      .cnt   (cat_q[c])
    );
  end

  run_checker_cnt #(.CNT_W(CNT_W)) u_total (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (hit && scored),
    .cnt   (total_pass)
  );

  assign cat_pass   = cat_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign wd_expired = wd_exp_q;
  assign mem_addr   = mem_addr_q;
  assign ref_addr   = ref_addr_q;
endmodule

// File: tb/tb_run_checker.sv
// Randomized bench for run_checker: run length, scan addressing and per-category
// scoring checked against a list-level reference model.

module tb_run_checker;
  localparam int DATA_W = 32, NOP_LIMIT = 9, WATCHDOG = 500, NUM_WORDS = 22;
  localparam int ADDR_W = 8, NUM_CAT = 6, CAT_W = 3, CNT_W = 8;

  function automatic int code_of(input int i);
    if (i == 3 || i == 4 || i == 6) return 0;
    if (i >= 7  && i <= 10) return 1;
    if (i >= 11 && i <= 14) return 2;
    if (i >= 15 && i <= 18) return 3;
    if (i == 19 || i == 20) return 4;
    if (i == 21) return 5;
    return 7;
  endfunction

  function automatic logic [NUM_WORDS*CAT_W-1:0] build_map();
    logic [NUM_WORDS*CAT_W-1:0] m;
    m = '0;
    for (int i = 0; i < NUM_WORDS; i++) m[i*CAT_W +: CAT_W] = CAT_W'(code_of(i));
    return m;
  endfunction

  localparam logic [NUM_WORDS*CAT_W-1:0] MAP = build_map();

  logic                     clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [DATA_W-1:0]        inst = '0, mem_rdata = '0, ref_rdata = '0;
  logic [ADDR_W-1:0]        mem_addr, ref_addr;
  logic                     busy, done, wd_expired;
  logic [NUM_CAT*CNT_W-1:0] cat_pass;
  logic [CNT_W-1:0]         total_pass;

  run_checker #(
    .DATA_W(DATA_W), .NOP_LIMIT(NOP_LIMIT), .WATCHDOG(WATCHDOG), .NUM_WORDS(NUM_WORDS),
    .ADDR_W(ADDR_W), .NUM_CAT(NUM_CAT), .CAT_W(CAT_W), .CAT_MAP(MAP), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .inst(inst),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .ref_addr(ref_addr), .ref_rdata(ref_rdata),
    .busy(busy), .done(done), .wd_expired(wd_expired),
    .cat_pass(cat_pass), .total_pass(total_pass)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] mem_arr [NUM_WORDS];
  logic [DATA_W-1:0] ref_arr [NUM_WORDS];
  logic [DATA_W-1:0] inst_seq [WATCHDOG];

  // Synchronous memories: data is valid one cycle after the address.
  always @(posedge clk) begin
    mem_rdata <= (int'(mem_addr >> 2) < NUM_WORDS) ? mem_arr[int'(mem_addr >> 2)] : '0;
    ref_rdata <= (int'(ref_addr) < NUM_WORDS) ? ref_arr[int'(ref_addr)] : '0;
  end

  int vectors = 0, errors = 0;

  task automatic fill_inst(input int mode, input int nz);
    for (int p = 0; p < WATCHDOG; p++) begin
      case (mode)
        0:       inst_seq[p] = (p < nz) ? ($urandom() | 32'h1) : '0;
        1:       inst_seq[p] = $urandom() | 32'h100;
        default: inst_seq[p] = ($urandom_range(0, 3) != 0) ? '0 : ($urandom() | 32'h2);
      endcase
    end
  endtask

  task automatic fill_mem(input int n_bad);
    for (int i = 0; i < NUM_WORDS; i++) begin
      mem_arr[i] = $urandom();
      ref_arr[i] = mem_arr[i];
    end
    for (int j = 0; j < n_bad; j++) begin
      int w;
      w = $urandom_range(0, NUM_WORDS - 1);
      ref_arr[w] = mem_arr[w] ^ (32'h1 << $urandom_range(0, 31));
    end
  endtask

  // Run length: first position closing NOP_LIMIT consecutive zeros, capped by the watchdog.
  function automatic int model_len();
    for (int p = NOP_LIMIT - 1; p < WATCHDOG; p++) begin
      bit all_zero;
      all_zero = 1'b1;
      for (int q = p - NOP_LIMIT + 1; q <= p; q++) if (inst_seq[q] != '0) all_zero = 1'b0;
      if (all_zero) return p + 1;
    end
    return WATCHDOG;
  endfunction

  task automatic do_run(input bit start_mid, input bit rst_scan);
    int r, et;
    int ec [NUM_CAT];
    bit wdx;
    logic [NUM_CAT*CNT_W-1:0] exp_cat;
    r = model_len();
    wdx = (r == WATCHDOG);
    et = 0;
    for (int c = 0; c < NUM_CAT; c++) ec[c] = 0;
    for (int i = 0; i < NUM_WORDS; i++)
      if (code_of(i) < NUM_CAT && mem_arr[i] == ref_arr[i]) begin
        ec[code_of(i)] = (ec[code_of(i)] < 255) ? ec[code_of(i)] + 1 : 255;
        et = (et < 255) ? et + 1 : 255;
      end
    exp_cat = '0;
    for (int c = 0; c < NUM_CAT; c++) exp_cat[c*CNT_W +: CNT_W] = CNT_W'(ec[c]);

    @(negedge clk); start = 1'b1;
    for (int k = 1; k <= r + 24; k++) begin
      int eidx;
      @(negedge clk);
      start = 1'b0;
      inst  = (k <= WATCHDOG) ? inst_seq[k-1] : '0;
      if (start_mid && k == 2 && r > 3) start = 1'b1;
      eidx = (k >= r + 1 && k - r - 1 < NUM_WORDS) ? k - r - 1 : 0;
      vectors++;
      if (busy !== (k <= r + 23)) begin
        errors++; $display("FAIL busy k=%0d got %b want %b", k, busy, (k <= r + 23));
      end
      vectors++;
      if (ref_addr !== ADDR_W'(eidx) || mem_addr !== ADDR_W'(4 * eidx)) begin
        errors++; $display("FAIL addr k=%0d got mem %0d ref %0d want mem %0d ref %0d",
                           k, mem_addr, ref_addr, 4 * eidx, eidx);
      end
      if (k == 1) begin
        vectors++;
        if (done !== 1'b0 || wd_expired !== 1'b0 || total_pass !== '0 || cat_pass !== '0) begin
          errors++; $display("FAIL start_clear got done %b wd %b total %0d cat %h want all 0",
                             done, wd_expired, total_pass, cat_pass);
        end
      end
      if (rst_scan && k == r + 11) begin
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({busy, done, wd_expired, mem_addr, ref_addr, total_pass, cat_pass} !== '0) begin
          errors++; $display("FAIL async_reset got busy %b done %b wd %b mem %0d ref %0d total %0d cat %h want 0",
                             busy, done, wd_expired, mem_addr, ref_addr, total_pass, cat_pass);
        end
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0) begin
          errors++; $display("FAIL idle_after_reset got busy %b done %b want 0 0", busy, done);
        end
        return;
      end
    end
    vectors++;
    if (done !== 1'b1 || wd_expired !== wdx) begin
      errors++; $display("FAIL end_flags got done %b wd %b want 1 %b", done, wd_expired, wdx);
    end
    vectors++;
    if (cat_pass !== exp_cat || total_pass !== CNT_W'(et)) begin
      errors++; $display("FAIL scores got cat %h total %0d want cat %h total %0d",
                         cat_pass, total_pass, exp_cat, et);
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (done !== 1'b1 || busy !== 1'b0 || total_pass !== CNT_W'(et) || cat_pass !== exp_cat) begin
      errors++; $display("FAIL hold got done %b busy %b total %0d want 1 0 %0d", done, busy, total_pass, et);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({busy, done, wd_expired, mem_addr, ref_addr, total_pass, cat_pass} !== '0) begin
      errors++; $display("FAIL reset_state got busy %b done %b total %0d want 0", busy, done, total_pass);
    end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL stay_idle got busy %b done %b want 0 0", busy, done);
    end
  endtask

  task automatic test_nop_end();
    fill_inst(0, 5);
    fill_mem(0);
    do_run(1'b0, 1'b0);
    vectors++;
    if (total_pass !== 8'd18 || cat_pass !== {8'd1, 8'd2, 8'd4, 8'd4, 8'd4, 8'd3}) begin
      errors++; $display("FAIL all_match got cat %h total %0d want 010204040403 18", cat_pass, total_pass);
    end
  endtask

  task automatic test_watchdog();
    fill_inst(1, 0);
    fill_mem(0);
    do_run(1'b0, 1'b0);
    fill_inst(0, WATCHDOG - NOP_LIMIT);   // both limits hit on the same edge
    do_run(1'b0, 1'b0);
  endtask

  task automatic test_mismatch();
    fill_inst(0, 3);
    fill_mem(0);
    ref_arr[9] = ~mem_arr[9];
    do_run(1'b0, 1'b0);
    vectors++;
    if (total_pass !== 8'd17 || cat_pass[1*CNT_W +: CNT_W] !== 8'd3) begin
      errors++; $display("FAIL word9_miss got cat1 %0d total %0d want 3 17",
                         cat_pass[1*CNT_W +: CNT_W], total_pass);
    end
    ref_arr[9] = mem_arr[9];
    ref_arr[0] = ~mem_arr[0];
    do_run(1'b0, 1'b0);
    vectors++;
    if (total_pass !== 8'd18) begin
      errors++; $display("FAIL unscored_miss got total %0d want 18", total_pass);
    end
  endtask

  task automatic test_start_ignored();
    fill_inst(0, 12);
    fill_mem(2);
    do_run(1'b1, 1'b0);
  endtask

  task automatic test_reset_mid_scan();
    fill_inst(0, 7);
    fill_mem(1);
    do_run(1'b0, 1'b1);
    do_run(1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 10; n++) begin
      fill_inst(2, 0);
      fill_mem($urandom_range(0, 6));
      do_run(n[0], 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_nop_end();
    test_watchdog();
    test_mismatch();
    test_start_ignored();
    test_reset_mid_scan();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/run_checker.md
RUN_CHECKER -- requirements
Module: run_checker

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, instruction/data word width.
REQ-002 The block SHALL have parameter NOP_LIMIT, default 9, consecutive all-zero instructions that end a run.
REQ-003 The block SHALL have parameter WATCHDOG, default 500, maximum run cycles.
REQ-004 The block SHALL have parameter NUM_WORDS, default 22, result words scanned from word 0.
REQ-005 The block SHALL have parameter ADDR_W, default 8, byte-address width of mem_addr.
REQ-006 The block SHALL have parameter NUM_CAT, default 6, number of scoring categories.
REQ-007 The block SHALL have parameter CAT_W, default 3, width of one category code.
REQ-008 The block SHALL have parameter CAT_MAP, default all-ones, NUM_WORDS*CAT_W bits; word i's code is bits [i*CAT_W +: CAT_W]; a code >= NUM_CAT means unscored.
REQ-009 The block SHALL have parameter CNT_W, default 8, counter width.
REQ-010 The block SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-011 The block SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-012 The block SHALL have port start, input, 1, single-cycle run request.
REQ-013 The block SHALL have port inst, input, DATA_W, instruction currently fetched by the core.
REQ-014 The block SHALL have port mem_addr, output, ADDR_W, byte address to data memory, always word-aligned.
REQ-015 The block SHALL have port mem_rdata, input, DATA_W, data memory word, valid one cycle after mem_addr.
REQ-016 The block SHALL have port ref_addr, output, ADDR_W, word index to reference table, same timing as mem_addr.
REQ-017 The block SHALL have port ref_rdata, input, DATA_W, expected word, valid one cycle after ref_addr.
REQ-018 The block SHALL have outputs busy (1), done (1), wd_expired (1), cat_pass (NUM_CAT*CNT_W, category c at [c*CNT_W +: CNT_W]) and total_pass (CNT_W).

Function
REQ-019 The block SHALL implement states IDLE, RUN, SCAN, DONE.
REQ-020 IDLE/DONE with start=1 SHALL go to RUN next cycle, clearing nop count, watchdog count, all pass counters, wd_expired and done.
REQ-021 start SHALL be ignored in RUN and SCAN.
REQ-022 In each RUN cycle, watchdog count SHALL increment; nop count SHALL increment if inst==0, else clear to 0.
REQ-023 RUN SHALL go to SCAN the cycle after a sampling edge where the updated nop count equals NOP_LIMIT or the updated watchdog count equals WATCHDOG.
REQ-024 wd_expired SHALL be set when the watchdog limit ends the run, including the case where both limits are reached on the same edge.
REQ-025 In SCAN, the block SHALL issue index i = 0..NUM_WORDS-1, one per cycle, with mem_addr = 4*i and ref_addr = i.
REQ-026 The compare for index i SHALL occur one cycle after issue, using mem_rdata == ref_rdata over the full DATA_W.
REQ-027 On a match with code c < NUM_CAT, cat_pass[c] and total_pass SHALL each increment by 1; an unscored match SHALL change no counter.
REQ-028 Counters SHALL saturate at 2^CNT_W-1.
REQ-029 SCAN SHALL go to DONE the cycle after the compare of index NUM_WORDS-1, giving SCAN a length of NUM_WORDS+1 cycles.
REQ-030 busy SHALL be 1 in RUN and SCAN; done SHALL be 1 in DONE only; results SHALL hold in DONE until the next start.
REQ-031 mem_addr and ref_addr SHALL be 0 outside SCAN.

Reset
REQ-032 rst_n=0 SHALL immediately force IDLE, all counters 0, busy=0, done=0, wd_expired=0, mem_addr=0 and ref_addr=0, including mid-RUN or mid-SCAN.
REQ-033 After rst_n deasserts, the block SHALL stay in IDLE until start.

Verification
REQ-034 Start, then 5 nonzero instructions followed by 9 zeros (NOP_LIMIT=9) -> busy drops 22+1 cycles after SCAN entry, with wd_expired=0.
REQ-035 inst held nonzero (WATCHDOG=500) -> SCAN entered after exactly 500 RUN cycles, with wd_expired=1.
REQ-036 Memory equals reference for all 22 words, with CAT_MAP codes {3,4,6->0; 7-10->1; 11-14->2; 15-18->3; 19,20->4; 21->5; else 7} -> cat_pass = {1,2,4,4,4,3}, total_pass = 18.
REQ-037 Mismatch injected only at word 9 -> cat_pass[1]=3 and total_pass=17; mismatch at an unscored word -> counts unchanged.
REQ-038 rst_n pulsed low at SCAN index 10 -> all outputs are 0 within the same cycle; a new start runs cleanly with identical results.
REQ-039 start pulsed during RUN -> no effect; start pulsed in DONE -> counters clear and a new run begins.
